// File: rtl/video_fetch_seq.sv
// Per-line DRAM word fetch sequencer for the video pipeline: frame-shadowed mode
// config, row/column tracking and per-mode address generation.
module video_fetch_seq #(
    parameter int ADDR_W = 21,
    parameter int ROW_W  = 9,
    parameter int COL_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              line_active,
    input  logic [7:0]        vconf,
    input  logic [7:0]        vpage,
    input  logic [ROW_W-1:0]  y_offs,
    input  logic              fetch_ack,
    input  logic [15:0]       fetch_data,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              line_done,
    output logic              overrun,
    output logic [1:0]        act_vmod,
    output logic [1:0]        act_rres
);

    // state | meaning
    // IDLE  | no line in progress since frame start, reset or abort
    // REQ   | fetching words of the current line, fetch_req high
    // DONE  | last word of the line acked, waiting for the next line
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       vmod_q, vmod_d;
    logic [1:0]       rres_q, rres_d;
    logic [7:0]       vpage_q, vpage_d;
    logic [ROW_W-1:0] yoffs_q, yoffs_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] eff_row_q, eff_row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [15:0]      chr_q, chr_d;
    logic             line_done_q, line_done_d;
    logic             overrun_q, overrun_d;

    logic [8:0]       width_px;
    logic [COL_W-1:0] words;
    logic             last_word;
    logic             ack_taken;
    logic [8:0]       r9;
    logic [7:0]       c8;
    logic [20:0]      addr21;
    logic             unused_vconf;

    assign unused_vconf = ^vconf[5:2];

    always_comb begin
        case (rres_q)
            2'd0:    width_px = 9'd256;
            2'd3:    width_px = 9'd360;
            default: width_px = 9'd320;
        endcase
        case (vmod_q)
            2'd0:    words = COL_W'(width_px >> 3);
            2'd2:    words = COL_W'(width_px >> 1);
            default: words = COL_W'(width_px >> 2);
        endcase
    end

    assign last_word = (col_q == words - COL_W'(1));
    assign ack_taken = (state_q == ST_REQ) && fetch_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (line_start && line_active) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (line_start) begin
                        state_d = line_active ? ST_REQ : ST_IDLE;
                    end else if (fetch_ack && last_word) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        vmod_d      = vmod_q;
        rres_d      = rres_q;
        vpage_d     = vpage_q;
        yoffs_d     = yoffs_q;
        row_d       = row_q;
        eff_row_d   = eff_row_q;
        col_d       = col_q;
        chr_d       = chr_q;
        overrun_d   = overrun_q;
        line_done_d = ack_taken && last_word && !frame_start;

        // An ack in the same cycle as a restart is consumed before the column clears.
        if (ack_taken) begin
            col_d = col_q + COL_W'(1);
            if (col_q[1:0] == 2'b00) begin
                chr_d = fetch_data;
            end
        end

        if (frame_start) begin
            vmod_d  = vconf[1:0];
            rres_d  = vconf[7:6];
            vpage_d = vpage;
            yoffs_d = y_offs;
            row_d   = '0;
        end else if (line_start && line_active) begin
            row_d     = row_q + ROW_W'(1);
            eff_row_d = row_q + yoffs_q;
            col_d     = '0;
        end

        if ((state_q == ST_REQ) && line_start) begin
            overrun_d = 1'b1;
        end else if (frame_start) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vmod_q      <= 2'd0;
            rres_q      <= 2'd0;
            vpage_q     <= 8'd0;
            yoffs_q     <= '0;
            row_q       <= '0;
            eff_row_q   <= '0;
            col_q       <= '0;
            chr_q       <= 16'd0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            vmod_q      <= vmod_d;
            rres_q      <= rres_d;
            vpage_q     <= vpage_d;
            yoffs_q     <= yoffs_d;
            row_q       <= row_d;
            eff_row_q   <= eff_row_d;
            col_q       <= col_d;
            chr_q       <= chr_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
        end
    end

    // Address depends only on registers that move on an ack, so it is stable under a stall.
    always_comb begin
        r9 = 9'(eff_row_q);
        c8 = 8'(col_q);
        case (vmod_q)
            2'd0: begin
                if (!c8[0]) begin
                    addr21 = {vpage_q, 1'b0, r9[7:6], r9[2:0], r9[5:3], c8[4:1]};
                end else begin
                    addr21 = {vpage_q, 1'b0, 3'b110, r9[7:3], c8[4:1]};
                end
            end
            2'd1: addr21 = {vpage_q[7:3], r9[8:0], c8[6:0]};
            2'd2: addr21 = {vpage_q[7:4], r9[8:0], c8[7:0]};
            default: begin
                case (c8[1:0])
                    2'd0:    addr21 = {vpage_q, r9[8:3], 1'b0, c8[7:2]};
                    2'd1:    addr21 = {vpage_q, r9[8:3], 1'b1, c8[7:2]};
                    2'd2:    addr21 = {vpage_q[7:1], ~vpage_q[0], 3'b000, chr_q[7:0], r9[2:1]};
                    default: addr21 = {vpage_q[7:1], ~vpage_q[0], 3'b000, chr_q[15:8], r9[2:1]};
                endcase
            end
        endcase
    end

    always_comb begin
        fetch_req  = (state_q == ST_REQ);
        fetch_addr = ADDR_W'(addr21);
        line_done  = line_done_q;
        overrun    = overrun_q;
        act_vmod   = vmod_q;
        act_rres   = rres_q;
    end

endmodule

// File: tb/tb_video_fetch_seq.sv
// Bench for video_fetch_seq: a line-level reference model checked every cycle,
// plus directed scenarios with hand-computed addresses and word counts.
module tb_video_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        line_active = 1'b0;
    logic [7:0]  vconf = 8'd0;
    logic [7:0]  vpage = 8'd0;
    logic [8:0]  y_offs = 9'd0;
    logic        fetch_ack = 1'b0;
    logic [15:0] fetch_data = 16'd0;
    logic        fetch_req;
    logic [20:0] fetch_addr;
    logic        line_done;
    logic        overrun;
    logic [1:0]  act_vmod;
    logic [1:0]  act_rres;

    int checks = 0;
    int failures = 0;

    video_fetch_seq #(.ADDR_W(21), .ROW_W(9), .COL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .line_start (line_start),
        .line_active(line_active),
        .vconf      (vconf),
        .vpage      (vpage),
        .y_offs     (y_offs),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .line_done  (line_done),
        .overrun    (overrun),
        .act_vmod   (act_vmod),
        .act_rres   (act_rres)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_valid = 0;
    bit m_busy, m_done, m_ovr;
    int m_col, m_row, m_line_r, m_chr;
    int m_vmod, m_rres, m_vpage, m_yoffs;

    function automatic int words_of(input int vm, input int rr);
        int width;
        width = (rr == 0) ? 256 : (rr == 3) ? 360 : 320;
        case (vm)
            0: return width / 8;
            2: return width / 2;
            default: return width / 4;
        endcase
    endfunction

    function automatic int exp_addr(input int vm, input int pg, input int r, input int col, input int chr);
        case (vm)
            0: begin
                if (col % 2 == 0)
                    return pg * 8192 + ((r / 64) % 4) * 1024 + (r % 8) * 128 + ((r / 8) % 8) * 16 + (col / 2) % 16;
                else
                    return pg * 8192 + 6 * 512 + ((r / 8) % 32) * 16 + (col / 2) % 16;
            end
            1: return (pg / 8) * 65536 + r * 128 + col % 128;
            2: return (pg / 16) * 131072 + r * 256 + col % 256;
            default: begin
                case (col % 4)
                    0: return pg * 8192 + (r / 8) * 128 + col / 4;
                    1: return pg * 8192 + (r / 8) * 128 + 64 + col / 4;
                    2: return (pg ^ 1) * 8192 + (chr % 256) * 4 + (r / 2) % 4;
                    default: return (pg ^ 1) * 8192 + (chr / 256) * 4 + (r / 2) % 4;
                endcase
            end
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit was_busy;
        if (!rst_n) begin
            m_valid = 1; m_busy = 0; m_done = 0; m_ovr = 0;
            m_col = 0; m_row = 0; m_line_r = 0; m_chr = 0;
            m_vmod = 0; m_rres = 0; m_vpage = 0; m_yoffs = 0;
        end else begin
            was_busy = m_busy;
            m_done = 0;
            if (was_busy && fetch_ack) begin
                if (m_col % 4 == 0) m_chr = fetch_data;
                m_col++;
                if (m_col == words_of(m_vmod, m_rres)) begin
                    m_busy = 0;
                    if (!frame_start) m_done = 1;
                end
            end
            if (was_busy && line_start) m_ovr = 1;
            else if (frame_start) m_ovr = 0;
            if (frame_start) begin
                m_vmod = vconf[1:0]; m_rres = vconf[7:6];
                m_vpage = vpage; m_yoffs = y_offs;
                m_row = 0; m_busy = 0;
            end else if (line_start && line_active) begin
                m_line_r = (m_row + m_yoffs) % 512;
                m_row = (m_row + 1) % 512;
                m_busy = 1; m_col = 0;
            end else if (line_start && was_busy) begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_fetch_req", fetch_req, m_busy);
            if (m_busy)
                chk("cyc_fetch_addr", fetch_addr, exp_addr(m_vmod, m_vpage, m_line_r, m_col, m_chr));
            chk("cyc_line_done", line_done, m_done);
            chk("cyc_overrun", overrun, m_ovr);
            chk("cyc_act_vmod", act_vmod, m_vmod);
            chk("cyc_act_rres", act_rres, m_rres);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame(input logic [7:0] cfg, input logic [7:0] pg, input logic [8:0] yo);
        vconf = cfg; vpage = pg; y_offs = yo;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic start_line(input logic active);
        line_start = 1'b1; line_active = active;
        tick();
        line_start = 1'b0; line_active = 1'b0;
    endtask

    task automatic finish_line(input int budget, output int acks, output bit seen);
        acks = 0; seen = 0;
        fetch_ack = 1'b1;
        for (int i = 0; i < budget && !seen; i++) begin
            fetch_data = 16'($urandom);
            if (fetch_req) acks++;
            tick();
            if (line_done) seen = 1;
        end
        fetch_ack = 1'b0;
    endtask

    initial begin : main
        int  acks;
        bit  seen;

        repeat (3) tick();
        chk("rst_fetch_req", fetch_req, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_act_vmod", act_vmod, 0);
        rst_n = 1'b1;
        tick();

        // ZX, rres 0, page 5, row 0
        pulse_frame(8'h00, 8'h05, 9'd0);
        start_line(1'b1);
        chk("zx_addr0", fetch_addr, 21'h0A000);
        fetch_ack = 1'b1;
        tick();
        chk("zx_addr1", fetch_addr, 21'h0AC00);
        finish_line(100, acks, seen);
        chk("zx_words", acks + 1, 32);
        chk("zx_done_seen", seen, 1);
        tick();
        chk("zx_done_single", line_done, 0);
        chk("zx_overrun", overrun, 0);

        // ZX, rres 1, scrambled row 0xA7
        pulse_frame(8'h40, 8'h05, 9'h0A7);
        start_line(1'b1);
        chk("zx_r_addr0", fetch_addr, 21'h0ABC0);
        fetch_ack = 1'b1;
        tick();
        chk("zx_r_addr1", fetch_addr, 21'h0AD40);
        finish_line(100, acks, seen);
        chk("zx_r_words", acks + 1, 40);
        chk("zx_r_done_seen", seen, 1);

        // 256c, rres 1, page 0x30, y_offs 2; fourth line is row 3
        pulse_frame(8'h42, 8'h30, 9'd2);
        for (int l = 0; l < 3; l++) begin
            start_line(1'b1);
            finish_line(400, acks, seen);
            chk("c256_pre_done", seen, 1);
        end
        start_line(1'b1);
        chk("c256_addr0", fetch_addr, 21'h60500);
        fetch_ack = 1'b1;
        repeat (10) tick();
        fetch_ack = 1'b0;
        chk("c256_addr10", fetch_addr, 21'h6050A);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("c256_stall_hold", fetch_addr, 21'h6050A);
        end
        finish_line(400, acks, seen);
        chk("c256_words", acks + 10, 160);
        chk("c256_done_seen", seen, 1);

        // text, rres 0, page 0x12, row 6
        pulse_frame(8'h03, 8'h12, 9'd6);
        start_line(1'b1);
        chk("txt_char_addr", fetch_addr, 21'h24000);
        fetch_data = 16'h4241;
        fetch_ack = 1'b1;
        tick();
        chk("txt_attr_addr", fetch_addr, 21'h24040);
        fetch_data = 16'h1111;
        tick();
        chk("txt_font_lo", fetch_addr, 21'h26107);
        tick();
        chk("txt_font_hi", fetch_addr, 21'h2610B);
        vconf = 8'h41; vpage = 8'h08; y_offs = 9'd0;
        finish_line(200, acks, seen);
        chk("txt_words", acks + 3, 64);
        chk("txt_done_seen", seen, 1);
        repeat (3) tick();
        chk("shadow_hold_vmod", act_vmod, 3);
        frame_start = 1'b1;
        chk("shadow_pre_edge", act_vmod, 3);
        tick();
        frame_start = 1'b0;
        chk("shadow_new_vmod", act_vmod, 1);
        chk("shadow_new_rres", act_rres, 1);

        // 16c, 80 words: restart at word 40
        start_line(1'b1);
        fetch_ack = 1'b1;
        repeat (40) tick();
        chk("ovr_before", overrun, 0);
        line_start = 1'b1; line_active = 1'b1;
        tick();
        line_start = 1'b0; line_active = 1'b0;
        chk("ovr_set", overrun, 1);
        chk("ovr_restart_req", fetch_req, 1);
        chk("ovr_restart_addr", fetch_addr, 21'h10080);
        finish_line(200, acks, seen);
        chk("c16_words", acks, 80);
        chk("c16_done_seen", seen, 1);
        pulse_frame(8'h41, 8'h08, 9'd0);
        chk("ovr_cleared", overrun, 0);

        // overrun set and frame_start together: set wins, frame aborts
        start_line(1'b1);
        fetch_ack = 1'b1;
        repeat (5) tick();
        line_start = 1'b1; line_active = 1'b1; frame_start = 1'b1;
        tick();
        line_start = 1'b0; line_active = 1'b0; frame_start = 1'b0;
        fetch_ack = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        chk("ovr_frame_abort_req", fetch_req, 0);
        pulse_frame(8'h41, 8'h08, 9'd0);
        chk("ovr_cleared2", overrun, 0);

        // inactive line_start mid-line aborts
        start_line(1'b1);
        fetch_ack = 1'b1;
        repeat (5) tick();
        fetch_ack = 1'b0;
        start_line(1'b0);
        chk("abort_req", fetch_req, 0);
        chk("abort_overrun", overrun, 1);

        // frame_start coinciding with the last ack: no line_done
        start_line(1'b1);
        fetch_ack = 1'b1;
        repeat (79) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fetch_ack = 1'b0;
        chk("frame_abort_req", fetch_req, 0);
        chk("frame_abort_done", line_done, 0);
        chk("frame_abort_ovr", overrun, 0);
        tick();
        chk("frame_abort_done2", line_done, 0);

        // one-cycle reset during REQ with an ack pending
        start_line(1'b1);
        fetch_ack = 1'b1;
        repeat (3) tick();
        start_line(1'b1);
        chk("rst_mid_ovr_pre", overrun, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        fetch_ack = 1'b0;
        chk("rst_mid_req", fetch_req, 0);
        chk("rst_mid_ovr", overrun, 0);
        chk("rst_mid_vmod", act_vmod, 0);
        tick();
        start_line(1'b1);
        chk("post_rst_addr0", fetch_addr, 21'h00000);
        fetch_ack = 1'b1;
        tick();
        chk("post_rst_addr1", fetch_addr, 21'h00C00);
        finish_line(100, acks, seen);
        chk("post_rst_words", acks + 1, 32);
        chk("post_rst_done_seen", seen, 1);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
